// File: rtl/gate_response_checker_pkg.sv
// ============================================================================
// gate_response_checker_pkg
// Shared state encoding, obs bit indices and expected-vector function.
// Revision: 1.0
// ============================================================================
`default_nettype none

package gate_response_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int OBS_W    = 7;
    localparam int OBS_BNOT = 0;
    localparam int OBS_AND  = 1;
    localparam int OBS_OR   = 2;
    localparam int OBS_NAND = 3;
    localparam int OBS_NOR  = 4;
    localparam int OBS_XOR  = 5;
    localparam int OBS_XNOR = 6;

    function automatic logic [OBS_W-1:0] gate_expect(input logic va, input logic vb);
        logic [OBS_W-1:0] e;
        e           = '0;
        e[OBS_BNOT] = ~vb;
        e[OBS_AND]  = va & vb;
        e[OBS_OR]   = va | vb;
        e[OBS_NAND] = ~(va & vb);
        e[OBS_NOR]  = ~(va | vb);
        e[OBS_XOR]  = va ^ vb;
        e[OBS_XNOR] = ~(va ^ vb);
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gate_response_checker_ref_model.sv
// ============================================================================
// gate_ref_model
// Combinational golden model of the two-input gate block.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gate_ref_model
    import gate_response_checker_pkg::*;
(
    input  logic             va,
    input  logic             vb,
    output logic [OBS_W-1:0] exp_vec
);

    assign exp_vec = gate_expect(va, vb);

endmodule

`default_nettype wire

// File: rtl/gate_response_checker.sv
// ============================================================================
// gate_response_checker
// Latches applied (a,b) vectors, waits a settle time, checks the seven gate
// outputs and accumulates errors/coverage into a pass/fail verdict.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gate_response_checker
    import gate_response_checker_pkg::*;
#(
    parameter int ERR_W         = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vec_valid,
    input  logic             a,
    input  logic             b,
    input  logic [OBS_W-1:0] obs,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       cov,
    output logic [1:0]       first_err_vec,
    output logic [OBS_W-1:0] first_err_bits
);

    localparam int               C_CNT_W   = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LOAD = C_CNT_W'(SETTLE_CYCLES);
    localparam logic [ERR_W-1:0]   C_ERR_MAX  = '1;

    state_t             r_state, w_state_nxt;
    logic [1:0]         r_vec, w_vec_nxt;
    logic [C_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [ERR_W-1:0]   r_err, w_err_nxt;
    logic [3:0]         r_cov, w_cov_nxt;
    logic [1:0]         r_fev, w_fev_nxt;
    logic [OBS_W-1:0]   r_feb, w_feb_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_pass, w_pass_nxt;
    logic [OBS_W-1:0]   w_exp;
    logic [OBS_W-1:0]   w_diff;

    gate_ref_model u_ref (
        .va      (r_vec[1]),
        .vb      (r_vec[0]),
        .exp_vec (w_exp)
    );

    assign w_diff = obs ^ w_exp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_vec   <= '0;
            r_cnt   <= '0;
            r_err   <= '0;
            r_cov   <= '0;
            r_fev   <= '0;
            r_feb   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_cov   <= w_cov_nxt;
            r_fev   <= w_fev_nxt;
            r_feb   <= w_feb_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_cov_nxt   = r_cov;
        w_fev_nxt   = r_fev;
        w_feb_nxt   = r_feb;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_err_nxt   = '0;
                    w_cov_nxt   = '0;
                    w_fev_nxt   = '0;
                    w_feb_nxt   = '0;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (vec_valid) begin
                    w_vec_nxt = {a, b};
                    if (SETTLE_CYCLES == 0) begin
                        w_state_nxt = ST_CHECK;
                    end else begin
                        w_cnt_nxt   = C_CNT_LOAD;
                        w_state_nxt = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                // A fresh vector replaces the pending one and restarts the settle time.
                if (vec_valid) begin
                    w_vec_nxt = {a, b};
                    w_cnt_nxt = C_CNT_LOAD;
                end else if (r_cnt == C_CNT_W'(1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_CHECK;
                end else begin
                    w_cnt_nxt = r_cnt - C_CNT_W'(1);
                end
            end
            ST_CHECK: begin
                if (w_diff != '0) begin
                    if (r_err == '0) begin
                        w_fev_nxt = r_vec;
                        w_feb_nxt = w_diff;
                    end
                    if (r_err != C_ERR_MAX) begin
                        w_err_nxt = r_err + ERR_W'(1);
                    end
                end
                w_cov_nxt   = r_cov | (4'b0001 << r_vec);
                w_state_nxt = (w_cov_nxt == 4'b1111) ? ST_DONE : ST_WAIT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == ST_WAIT) || (w_state_nxt == ST_SETTLE) ||
                     (w_state_nxt == ST_CHECK);
        w_done_nxt = (w_state_nxt == ST_DONE);
        w_pass_nxt = (w_state_nxt == ST_DONE) && (w_err_nxt == '0);
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err;
    assign cov            = r_cov;
    assign first_err_vec  = r_fev;
    assign first_err_bits = r_feb;

endmodule

`default_nettype wire
